// File: rtl/mtimer_irq_gen.sv
// Machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp,
// 32-bit register bus and level timer interrupt.
module mtimer_irq_gen #(
  parameter logic [7:0]  PRESC_RST = 8'd0,
  parameter logic [63:0] CMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_t_irq
);

  localparam logic [2:0] A_MLO  = 3'd0;
  localparam logic [2:0] A_MHI  = 3'd1;
  localparam logic [2:0] A_CLO  = 3'd2;
  localparam logic [2:0] A_CHI  = 3'd3;
  localparam logic [2:0] A_CTRL = 3'd4;

  logic [63:0] mtime, mtime_nxt;
  logic [63:0] cmp, cmp_nxt;
  logic        en, en_nxt;
  logic [7:0]  presc, presc_nxt;
  logic [7:0]  pre_cnt, pre_nxt;
  logic [31:0] shadow, shadow_nxt;
  logic [31:0] rdata_nxt;
  logic        tick;
  logic        wr, rd;
  logic [2:0]  sel;
  logic        unused_addr;

  assign sel         = i_addr[4:2];
  assign wr          = i_req & i_we;
  assign rd          = i_req & ~i_we;
  assign unused_addr = ^i_addr[1:0];
  assign tick        = en && (pre_cnt == presc);

  always_comb begin
    mtime_nxt  = tick ? mtime + 64'd1 : mtime;
    pre_nxt    = en ? (tick ? 8'd0 : pre_cnt + 8'd1) : pre_cnt;
    cmp_nxt    = cmp;
    en_nxt     = en;
    presc_nxt  = presc;
    shadow_nxt = shadow;
    rdata_nxt  = 32'd0;
    if (wr) begin
      case (sel)
        A_MLO:  mtime_nxt = {mtime[63:32], i_wdata};
        A_MHI:  mtime_nxt = {i_wdata, mtime[31:0]};
        A_CLO:  cmp_nxt   = {cmp[63:32], i_wdata};
        A_CHI:  cmp_nxt   = {i_wdata, cmp[31:0]};
        A_CTRL: begin
          en_nxt    = i_wdata[0];
          presc_nxt = i_wdata[15:8];
          pre_nxt   = 8'd0;
        end
        default: ;
      endcase
    end
    // LO read snapshots the upper half so a following HI read is coherent
    if (rd) begin
      case (sel)
        A_MLO: begin
          rdata_nxt  = mtime[31:0];
          shadow_nxt = mtime[63:32];
        end
        A_MHI:  rdata_nxt = shadow;
        A_CLO:  rdata_nxt = cmp[31:0];
        A_CHI:  rdata_nxt = cmp[63:32];
        A_CTRL: rdata_nxt = {16'd0, presc, 7'd0, en};
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime   <= 64'd0;
      cmp     <= CMP_RST;
      en      <= 1'b1;
      presc   <= PRESC_RST;
      pre_cnt <= 8'd0;
      shadow  <= 32'd0;
      o_ack   <= 1'b0;
      o_rdata <= 32'd0;
      o_t_irq <= 1'b0;
    end else begin
      mtime   <= mtime_nxt;
      cmp     <= cmp_nxt;
      en      <= en_nxt;
      presc   <= presc_nxt;
      pre_cnt <= pre_nxt;
      shadow  <= shadow_nxt;
      o_ack   <= i_req;
      o_rdata <= rdata_nxt;
      o_t_irq <= (mtime >= cmp);
    end
  end

endmodule
